// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI master sequencer.
// Optional build macro: SPI_MASTER_LOOPBACK_EN (adds a loopback input port to spi_master_ctrl).
package spi_ctrl_pkg;

  localparam int DATA_W       = 8;
  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_CS_SETUP = 2;
  localparam int DEF_CS_HOLD  = 2;
  localparam int TMR_W        = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SCK_LO = 3'd2,
    SCK_HI = 3'd3,
    HOLD   = 3'd4,
    DONE   = 3'd5
  } state_e;

  // States in which a transfer owns the bus (CS asserted unless in loopback).
  function automatic logic in_transfer(state_e s);
    return (s == SETUP) || (s == SCK_LO) || (s == SCK_HI) || (s == HOLD);
  endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable down-counter that times each sequencer phase.
// expire_o pulses in the last cycle of a phase loaded with N (N cycles long).
module spi_phase_timer
  import spi_ctrl_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expire_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == W'(1));

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master sequencer: one 8-bit MSB-first transfer per accepted command.
// Optional build macro: SPI_MASTER_LOOPBACK_EN (internal MOSI->MISO loopback with CS held high).
//
// Handshake: a command is accepted on a rising clk edge where cmd_valid && cmd_ready;
// cmd_ready is high only in IDLE, commands offered while busy are dropped, and
// rsp_valid is a single-cycle pulse with rsp_rdata held until the next pulse.
module spi_master_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int CS_SETUP = DEF_CS_SETUP,
  parameter int CS_HOLD  = DEF_CS_HOLD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic              cmd_wr,
  input  logic              cmd_rd,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              SCLK,
  output logic              CS,
  output logic              MOSI,
  input  logic              MISO,
  output logic              wr_en,
  output logic              rd_en,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic              loopback,
`endif
  output state_e            dbg_state
);

  state_e state_q, state_d;

  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic              lb_q, lb_d;
  logic              sclk_q, sclk_d;
  logic              cs_q, cs_d;
  logic              mosi_q, mosi_d;

  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_exp;

  logic              loopback_in;
  logic              miso_bit;
  logic              sample_bit;

`ifdef SPI_MASTER_LOOPBACK_EN
  assign loopback_in = loopback;
`else
  assign loopback_in = 1'b0;
`endif

  // A floating MISO (slave not reading) must shift in as 0, never X/Z.
  assign miso_bit   = (MISO === 1'b1);
  assign sample_bit = lb_q ? mosi_q : miso_bit;

  spi_phase_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .expire_o  (tmr_exp)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid) state_d = SETUP;
      SETUP:   if (tmr_exp) state_d = SCK_LO;
      SCK_LO:  if (tmr_exp) state_d = SCK_HI;
      SCK_HI:  if (tmr_exp) state_d = (bit_cnt_q == 3'd7) ? HOLD : SCK_LO;
      HOLD:    if (tmr_exp) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE) && !reset;
    busy      = (state_q != IDLE);
    rsp_valid = (state_q == DONE);
    tmr_load  = (state_d != state_q);
    tmr_val   = '0;
    case (state_d)
      SETUP:          tmr_val = TMR_W'(CS_SETUP);
      SCK_LO, SCK_HI: tmr_val = TMR_W'(CLK_DIV);
      HOLD:           tmr_val = TMR_W'(CS_HOLD);
      default:        tmr_val = '0;
    endcase
  end

  // Pin registers are computed from the next state so SCLK/CS/MOSI leave flops in step with the FSM.
  always_comb begin
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rdata_d   = rdata_q;
    bit_cnt_d = bit_cnt_q;
    wr_en_d   = wr_en_q;
    rd_en_d   = rd_en_q;
    lb_d      = lb_q;

    if (state_q == IDLE && cmd_valid) begin
      tx_sr_d   = cmd_wdata;
      bit_cnt_d = 3'd0;
      wr_en_d   = cmd_wr;
      rd_en_d   = cmd_rd;
      lb_d      = loopback_in;
    end
    if (state_q == SCK_LO && state_d == SCK_HI) begin
      rx_sr_d = {rx_sr_q[DATA_W-2:0], sample_bit};
    end
    if (state_q == SCK_HI && state_d == SCK_LO) begin
      tx_sr_d   = {tx_sr_q[DATA_W-2:0], 1'b0};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
    if (state_q == HOLD && state_d == DONE) begin
      rdata_d = rx_sr_q;
    end
    if (state_q == DONE) begin
      wr_en_d = 1'b0;
      rd_en_d = 1'b0;
    end

    cs_d   = !(in_transfer(state_d) && !lb_d);
    sclk_d = (state_d == SCK_HI);
    mosi_d = in_transfer(state_d) ? tx_sr_d[DATA_W-1] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rdata_q   <= '0;
      bit_cnt_q <= 3'd0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      lb_q      <= 1'b0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rdata_q   <= rdata_d;
      bit_cnt_q <= bit_cnt_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      lb_q      <= lb_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
    end
  end

  assign SCLK      = sclk_q;
  assign CS        = cs_q;
  assign MOSI      = mosi_q;
  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;
  assign rsp_rdata = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: instance 0 uses default timing, instance 1 the
// fastest legal timing; a behavioural mode-0 slave model sits on each SPI bus.
module tb_spi_master_ctrl;
  import spi_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic       cmd_valid [2];
  logic       cmd_ready [2];
  logic [7:0] cmd_wdata;
  logic       cmd_wr;
  logic       cmd_rd;
  logic       rsp_valid [2];
  logic [7:0] rsp_rdata [2];
  logic       busy      [2];
  logic       sclk      [2];
  logic       cs        [2];
  logic       mosi      [2];
  logic       miso      [2];
  logic       wr_en     [2];
  logic       rd_en     [2];
  state_e     dbg_state [2];
`ifdef SPI_MASTER_LOOPBACK_EN
  logic       loopback  [2];
`endif

  int n_vec = 0;
  int n_err = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int DIV = (g == 0) ? 4 : 2;
    localparam int SET = (g == 0) ? 2 : 1;
    localparam int HLD = (g == 0) ? 2 : 1;
    spi_master_ctrl #(.CLK_DIV(DIV), .CS_SETUP(SET), .CS_HOLD(HLD)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .cmd_valid(cmd_valid[g]),
      .cmd_ready(cmd_ready[g]),
      .cmd_wdata(cmd_wdata),
      .cmd_wr   (cmd_wr),
      .cmd_rd   (cmd_rd),
      .rsp_valid(rsp_valid[g]),
      .rsp_rdata(rsp_rdata[g]),
      .busy     (busy[g]),
      .SCLK     (sclk[g]),
      .CS       (cs[g]),
      .MOSI     (mosi[g]),
      .MISO     (miso[g]),
      .wr_en    (wr_en[g]),
      .rd_en    (rd_en[g]),
`ifdef SPI_MASTER_LOOPBACK_EN
      .loopback (loopback[g]),
`endif
      .dbg_state(dbg_state[g])
    );
  end

  // ---------------- slave model (mode 0, MSB first) ----------------
  logic [7:0] slv_tx    [2] = '{default: 8'h00};
  logic [7:0] slv_sh    [2] = '{default: 8'h00};
  logic [7:0] slv_rx_sh [2] = '{default: 8'h00};
  logic [7:0] slv_sdr   [2] = '{default: 8'h00};
  logic       cs_prev   [2] = '{default: 1'b1};
  logic       sclk_prev [2] = '{default: 1'b0};
  int slv_cnt  [2] = '{default: 0};
  int rises    [2] = '{default: 0};
  int cs_run   [2] = '{default: 0};
  int last_gap [2] = '{default: 0};
  int rd_viol  [2] = '{default: 0};
  int cs_low   [2] = '{default: 0};
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];

  always_comb begin
    for (int i = 0; i < 2; i++) miso[i] = (rd_en[i] && !cs[i]) ? slv_sh[i][7] : 1'b0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cs_prev[i] && !cs[i]) begin
        slv_sh[i]   = slv_tx[i];
        slv_cnt[i]  = 0;
        last_gap[i] = cs_run[i];
      end
      cs_run[i] = cs[i] ? cs_run[i] + 1 : 0;
      if (!cs[i]) cs_low[i] = cs_low[i] + 1;
      if (!sclk_prev[i] && sclk[i]) begin
        rises[i] = rises[i] + 1;
        if (!cs[i]) begin
          slv_rx_sh[i] = {slv_rx_sh[i][6:0], mosi[i]};
          slv_cnt[i]   = slv_cnt[i] + 1;
          if (slv_cnt[i] == 8 && wr_en[i]) begin
            slv_sdr[i] = slv_rx_sh[i];
            if (i == 1) got_q.push_back(slv_rx_sh[i]);
          end
        end
      end
      if (sclk_prev[i] && !sclk[i] && !cs[i]) slv_sh[i] = {slv_sh[i][6:0], 1'b0};
      if (rd_en[i] && cs[i] && !rsp_valid[i]) rd_viol[i] = rd_viol[i] + 1;
      cs_prev[i]   = cs[i];
      sclk_prev[i] = sclk[i];
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input int g, input logic [7:0] d, input logic wr, input logic rd,
                       output int lat, output logic [7:0] rdata);
    int n;
    cmd_wdata    = d;
    cmd_wr       = wr;
    cmd_rd       = rd;
    cmd_valid[g] = 1'b1;
    n = 0;
    while (!cmd_ready[g] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd_valid[g] = 1'b0;
    lat = 1;
    while (!rsp_valid[g] && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    rdata = rsp_rdata[g];
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    cmd_wdata = 8'h00;
    cmd_wr = 1'b0;
    cmd_rd = 1'b0;
    for (int i = 0; i < 2; i++) cmd_valid[i] = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
    for (int i = 0; i < 2; i++) loopback[i] = 1'b0;
`endif
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if ({cs[i], sclk[i], mosi[i], wr_en[i], rd_en[i], cmd_ready[i], rsp_valid[i], busy[i]} !== 8'b1000_0000) begin
        n_err++;
        $display("FAIL reset_pins[%0d]: got %b expected 10000000 (cs,sclk,mosi,wr,rd,ready,rsp,busy)", i,
                 {cs[i], sclk[i], mosi[i], wr_en[i], rd_en[i], cmd_ready[i], rsp_valid[i], busy[i]});
      end
      n_vec++;
      if (rsp_rdata[i] !== 8'h00) begin
        n_err++;
        $display("FAIL reset_rdata[%0d]: got %h expected 00", i, rsp_rdata[i]);
      end
      n_vec++;
      if (dbg_state[i] !== IDLE) begin
        n_err++;
        $display("FAIL reset_state[%0d]: got %0d expected %0d", i, dbg_state[i], IDLE);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (cmd_ready[i] !== 1'b1) begin
        n_err++;
        $display("FAIL ready_after_reset[%0d]: got %b expected 1", i, cmd_ready[i]);
      end
    end
  endtask

  task automatic test_write_read();
    int lat, r0, v0;
    logic [7:0] rd;
    r0 = rises[0];
    issue(0, 8'hA5, 1'b1, 1'b0, lat, rd);
    n_vec++;
    if (lat !== 69) begin n_err++; $display("FAIL write_latency: got %0d expected 69", lat); end
    n_vec++;
    if (busy[0] !== 1'b1) begin n_err++; $display("FAIL busy_at_rsp: got %b expected 1", busy[0]); end
    n_vec++;
    if (rises[0] - r0 !== 8) begin n_err++; $display("FAIL write_sclk_rises: got %0d expected 8", rises[0] - r0); end
    n_vec++;
    if (slv_sdr[0] !== 8'hA5) begin n_err++; $display("FAIL write_slave_rx: got %h expected a5", slv_sdr[0]); end

    slv_tx[0] = 8'h3C;
    v0 = rd_viol[0];
    issue(0, 8'h00, 1'b0, 1'b1, lat, rd);
    n_vec++;
    if (rd !== 8'h3C) begin n_err++; $display("FAIL read_rdata: got %h expected 3c", rd); end
    n_vec++;
    if (lat !== 69) begin n_err++; $display("FAIL read_latency: got %0d expected 69", lat); end
    n_vec++;
    if (slv_sdr[0] !== 8'hA5) begin n_err++; $display("FAIL read_slave_untouched: got %h expected a5", slv_sdr[0]); end
    @(negedge clk);
    n_vec++;
    if ({rd_en[0], busy[0], rsp_valid[0]} !== 3'b000) begin
      n_err++;
      $display("FAIL read_idle_after: got %b expected 000 (rd_en,busy,rsp)", {rd_en[0], busy[0], rsp_valid[0]});
    end
    n_vec++;
    if (rsp_rdata[0] !== 8'h3C) begin n_err++; $display("FAIL rdata_held: got %h expected 3c", rsp_rdata[0]); end
    n_vec++;
    if (rd_viol[0] !== v0) begin n_err++; $display("FAIL rd_en_window: got %0d stray cycles expected 0", rd_viol[0] - v0); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [7:0] rd;
    exp_q.delete();
    got_q.delete();
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    issue(1, 8'h01, 1'b1, 1'b0, lat, rd);
    n_vec++;
    if (lat !== 35) begin n_err++; $display("FAIL b2b_latency_0: got %0d expected 35", lat); end
    issue(1, 8'h80, 1'b1, 1'b0, lat, rd);
    n_vec++;
    if (lat !== 35) begin n_err++; $display("FAIL b2b_latency_1: got %0d expected 35", lat); end
    n_vec++;
    if (last_gap[1] < 2) begin n_err++; $display("FAIL b2b_cs_gap: got %0d expected >=2", last_gap[1]); end
    n_vec++;
    if (got_q.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_vec++;
        if (got_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL b2b_byte_%0d: got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_ignore_busy();
    int n, lat, bad, r0, c0;
    cmd_wdata    = 8'h5A;
    cmd_wr       = 1'b1;
    cmd_rd       = 1'b0;
    cmd_valid[0] = 1'b1;
    n = 0;
    while (!cmd_ready[0] && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_wdata = 8'hFF;
    lat = 1;
    bad = 0;
    repeat (20) begin
      if (cmd_ready[0] !== 1'b0) bad++;
      @(negedge clk);
      lat++;
    end
    n_vec++;
    if (bad !== 0) begin n_err++; $display("FAIL ignore_ready_low: got %0d ready cycles expected 0", bad); end
    cmd_valid[0] = 1'b0;
    while (!rsp_valid[0] && lat < 2000) begin @(negedge clk); lat++; end
    n_vec++;
    if (lat !== 69) begin n_err++; $display("FAIL ignore_latency: got %0d expected 69", lat); end
    n_vec++;
    if (slv_sdr[0] !== 8'h5A) begin n_err++; $display("FAIL ignore_slave_rx: got %h expected 5a", slv_sdr[0]); end
    r0 = rises[0];
    c0 = cs_low[0];
    repeat (100) @(negedge clk);
    n_vec++;
    if ((rises[0] !== r0) || (cs_low[0] !== c0)) begin
      n_err++;
      $display("FAIL ignore_no_second: got %0d rises %0d cs-low cycles expected 0 0", rises[0] - r0, cs_low[0] - c0);
    end
  endtask

  task automatic test_reset_abort();
    int n, lat, bad, r0;
    logic [7:0] s0, rd;
    s0 = slv_sdr[0];
    r0 = rises[0];
    cmd_wdata    = 8'hC3;
    cmd_wr       = 1'b1;
    cmd_rd       = 1'b0;
    cmd_valid[0] = 1'b1;
    n = 0;
    while (!cmd_ready[0] && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    n = 0;
    while ((rises[0] - r0) < 3 && n < 500) begin @(negedge clk); n++; end
    n_vec++;
    if (rises[0] - r0 !== 3) begin n_err++; $display("FAIL abort_third_rise: got %0d rises expected 3", rises[0] - r0); end
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({cs[0], sclk[0], busy[0], rsp_valid[0], cmd_ready[0]} !== 5'b10000) begin
      n_err++;
      $display("FAIL abort_next_cycle: got %b expected 10000 (cs,sclk,busy,rsp,ready)",
               {cs[0], sclk[0], busy[0], rsp_valid[0], cmd_ready[0]});
    end
    reset = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (rsp_valid[0] !== 1'b0) bad++;
    end
    n_vec++;
    if (bad !== 0) begin n_err++; $display("FAIL abort_no_rsp: got %0d rsp cycles expected 0", bad); end
    n_vec++;
    if (slv_sdr[0] !== s0) begin n_err++; $display("FAIL abort_slave_untouched: got %h expected %h", slv_sdr[0], s0); end
    issue(0, 8'h0F, 1'b1, 1'b0, lat, rd);
    n_vec++;
    if (lat !== 69) begin n_err++; $display("FAIL after_abort_latency: got %0d expected 69", lat); end
    n_vec++;
    if (slv_sdr[0] !== 8'h0F) begin n_err++; $display("FAIL after_abort_slave_rx: got %h expected 0f", slv_sdr[0]); end
  endtask

`ifdef SPI_MASTER_LOOPBACK_EN
  task automatic test_loopback();
    int lat, r0, c0;
    logic [7:0] s0, rd;
    s0 = slv_sdr[0];
    r0 = rises[0];
    c0 = cs_low[0];
    @(negedge clk);
    loopback[0] = 1'b1;
    issue(0, 8'h96, 1'b1, 1'b0, lat, rd);
    loopback[0] = 1'b0;
    n_vec++;
    if (rd !== 8'h96) begin n_err++; $display("FAIL loopback_rdata: got %h expected 96", rd); end
    n_vec++;
    if (cs_low[0] !== c0) begin n_err++; $display("FAIL loopback_cs_high: got %0d cs-low cycles expected 0", cs_low[0] - c0); end
    n_vec++;
    if (slv_sdr[0] !== s0) begin n_err++; $display("FAIL loopback_slave_untouched: got %h expected %h", slv_sdr[0], s0); end
    n_vec++;
    if (rises[0] - r0 !== 8) begin n_err++; $display("FAIL loopback_sclk_rises: got %0d expected 8", rises[0] - r0); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) cmd_valid[i] = 1'b0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_back_to_back();
    test_ignore_busy();
    test_reset_abort();
`ifdef SPI_MASTER_LOOPBACK_EN
    test_loopback();
`endif
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached with %0d vectors applied", n_vec);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Single-channel SPI master sequencer that drives the SPI slave IP: generates SCLK and CS, shifts MOSI and captures MISO, and drives the slave's wr_en/rd_en strobes.
- Host side is a valid/ready command port with a one-cycle response pulse; one 8-bit transfer per command.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first; sits between the system bus glue and the slave.

Parameters:
- CLK_DIV, 4, SCLK half-period in clk cycles (legal values 2..255)
- CS_SETUP, 2, clk cycles with CS low before the first SCLK rise (legal values 1..15)
- CS_HOLD, 2, clk cycles with CS low after the last SCLK fall (legal values 1..15)
- DATA_W, 8, transfer width; fixed at 8 for this block

Ports:
- clk  input  1  system clock; all logic is on its rising edge
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  high only in IDLE
- cmd_wdata  input  8  byte to shift out on MOSI
- cmd_wr  input  1  transfer writes to the slave (drives wr_en)
- cmd_rd  input  1  transfer reads from the slave (drives rd_en)
- rsp_valid  output  1  one-cycle pulse when a transfer completes
- rsp_rdata  output  8  captured MISO byte; held until the next rsp_valid
- busy  output  1  high from accept until rsp_valid, inclusive
- SCLK  output  1  SPI clock
- CS  output  1  active-low chip select
- MOSI  output  1  master data out
- MISO  input  1  slave data in (may be Z when the slave's rd_en=0; a Z is captured as 0)
- wr_en  output  1  registered copy of cmd_wr for the active transfer
- rd_en  output  1  registered copy of cmd_rd for the active transfer

Behaviour:
- Reset values: CS=1, SCLK=0, MOSI=0, wr_en=0, rd_en=0, cmd_ready=0 during reset and 1 in the cycle after, rsp_valid=0, rsp_rdata=0, busy=0.
- FSM states: IDLE -> SETUP -> SCK_LO -> SCK_HI -> (SCK_LO | HOLD) -> DONE -> IDLE.
- IDLE:
  - CS=1, SCLK=0, cmd_ready=1.
  - When cmd_valid is high: latch cmd_wdata into tx_sr, latch cmd_wr/cmd_rd into wr_en/rd_en, clear bit_cnt, go to SETUP.
- SETUP:
  - CS=0, MOSI=tx_sr[7], held for CS_SETUP cycles, then go to SCK_LO.
- SCK_LO:
  - SCLK=0 for CLK_DIV cycles, then go to SCK_HI.
  - On that transition, SCLK rises and MISO is sampled into rx_sr[0] with rx_sr shifting left.
- SCK_HI:
  - SCLK=1 for CLK_DIV cycles.
  - At the end, if bit_cnt==7 go to HOLD; otherwise increment bit_cnt, shift tx_sr left (MOSI updates on the falling edge) and go to SCK_LO.
- HOLD:
  - SCLK=0, CS=0 for CS_HOLD cycles, then go to DONE.
- DONE:
  - CS=1, rsp_valid=1, rsp_rdata=rx_sr.
  - wr_en and rd_en clear on exit. Go to IDLE.
- Each transfer produces exactly 8 SCLK rising edges.
- Latency from the accept cycle to rsp_valid = 1 + CS_SETUP + 16*CLK_DIV + CS_HOLD clk cycles.
- CS is high for at least 2 clk cycles between transfers (DONE plus IDLE), which guarantees a CS falling edge for every transfer so the slave resets its bit counter.
- cmd_valid while busy is ignored; the command is not queued.
- cmd_wr=cmd_rd=0 is legal: the transfer runs in full, the slave ignores it, and rx is captured anyway.
- A reset asserted mid-transfer aborts the transfer in the next cycle: CS=1, SCLK=0, no rsp_valid.
- SCLK, CS and MOSI come directly from flops, with no combinational path from any input.

Optional Feature:
- Macro: SPI_MASTER_LOOPBACK_EN.
- When defined:
  - Adds input port loopback (1 bit), sampled at accept.
  - When loopback is set, the MISO sample uses the internal MOSI instead of the MISO pin, and CS stays 1 for the whole transfer so the slave is not disturbed; SCLK still toggles.
  - Resulting rsp_rdata == cmd_wdata.
- When undefined: the port is absent and MISO is always sampled from the pin.

Decomposition:
- Package spi_ctrl_pkg holds:
  - state enum (IDLE, SETUP, SCK_LO, SCK_HI, HOLD, DONE)
  - DATA_W constant
  - default CLK_DIV, CS_SETUP and CS_HOLD constants
- Sub-module spi_phase_timer: loadable down-counter with a one-cycle expire output. The FSM reloads it with CS_SETUP, CLK_DIV or CS_HOLD on each state entry.

Test Plan:
- Write then read, with defaults and the slave connected:
  - cmd_wdata=0xA5, cmd_wr=1, cmd_rd=0 -> slaveDataReceived=0xA5; rsp_valid exactly 69 cycles after accept; exactly 8 SCLK rises.
  - Next, slaveDataToSend=0x3C, cmd_rd=1, cmd_wr=0 -> rsp_rdata equals the slave's MISO sequence; rd_en high only while CS=0 or in DONE.
- CLK_DIV=2, CS_SETUP=1, CS_HOLD=1: back-to-back commands 0x01 then 0x80 -> latency 35 cycles each; CS high ≥2 cycles between transfers; both bytes received by the slave in order.
- cmd_valid held high during a transfer with cmd_wdata=0xFF -> cmd_ready=0 and the command is ignored; only the original 0x5A transfer completes.
- Reset pulsed after the 3rd SCLK rise of 0xC3 -> next cycle CS=1, SCLK=0, busy=0, rsp_valid never asserts; a following transfer of 0x0F completes correctly.
- SPI_MASTER_LOOPBACK_EN defined, loopback=1, cmd_wdata=0x96 -> rsp_rdata=0x96, CS stays 1, slave SDR unchanged.
